// File: rtl/gtfraw_vnc_lat_mon_mc.sv
// ---------------------------------------------------------------------------
// gtfraw_vnc_lat_mon_mc
// Multi-channel latency statistics engine. NUM_CH independent TX/RX event
// pairs share one free-running lat_clk timestamp. Each channel queues send
// timestamps in a small FIFO, turns every receive event into one delta
// (wrap-safe, minus an adjust factor, floored at 0) and keeps a saturating
// accumulator, a sample count and min/max of the adjusted deltas.
//
// Ports
//   lat_clk, lat_rstn     clock / asynchronous active-low reset
//   go                    level: run (1) or freeze (0)
//   clear                 pulse: clear FIFOs, stats and status (timer keeps running)
//   lat_pkt_cnt           samples per channel before done; 0 = unlimited
//   delta_adj_factor      subtracted from every raw delta
//   tx_event, rx_event    per-channel one-cycle send / receive pulses
//   rd_ch_sel             channel whose stats appear on rd_* (registered)
//   timer                 free-running timestamp
//   rd_accu/idx/max/min   selected channel statistics
//   ch_done               per channel: sample count reached lat_pkt_cnt
//   ch_overflow           sticky: tx_event dropped on full FIFO
//   ch_orphan             sticky: rx_event seen with empty FIFO
//   all_done              every channel done (never when lat_pkt_cnt == 0)
// ---------------------------------------------------------------------------
module gtfraw_vnc_lat_mon_mc #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned TIMER_WIDTH     = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned ACCU_WIDTH      = 32,
    localparam int unsigned SEL_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   lat_clk,
    input  logic                   lat_rstn,
    input  logic                   go,
    input  logic                   clear,
    input  logic [31:0]            lat_pkt_cnt,
    input  logic [TIMER_WIDTH-1:0] delta_adj_factor,
    input  logic [NUM_CH-1:0]      tx_event,
    input  logic [NUM_CH-1:0]      rx_event,
    input  logic [SEL_WIDTH-1:0]   rd_ch_sel,
    output logic [TIMER_WIDTH-1:0] timer,
    output logic [ACCU_WIDTH-1:0]  rd_accu,
    output logic [31:0]            rd_idx,
    output logic [TIMER_WIDTH-1:0] rd_max,
    output logic [TIMER_WIDTH-1:0] rd_min,
    output logic [NUM_CH-1:0]      ch_done,
    output logic [NUM_CH-1:0]      ch_overflow,
    output logic [NUM_CH-1:0]      ch_orphan,
    output logic                   all_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ch_state_t;

    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;

    logic [TIMER_WIDTH-1:0] timer_q;
    logic [ACCU_WIDTH-1:0]  accu_a [NUM_CH];
    logic [31:0]            idx_a  [NUM_CH];
    logic [TIMER_WIDTH-1:0] max_a  [NUM_CH];
    logic [TIMER_WIDTH-1:0] min_a  [NUM_CH];
    logic [4:0]             sel_ext;

    always_ff @(posedge lat_clk or negedge lat_rstn) begin
        if (!lat_rstn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign timer = timer_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t              state_q, state_d;
        logic [TIMER_WIDTH-1:0] fifo_mem [DEPTH];
        logic [FIFO_ADDR_WIDTH:0] wr_ptr, rd_ptr;
        logic                   full, empty, accept, pop, push;
        logic [31:0]            pop_cnt, pop_cnt_next;
        logic                   s1_valid;
        logic [TIMER_WIDTH-1:0] s1_ts, s1_head, raw, adj;
        logic [ACCU_WIDTH:0]    accu_sum;
        logic [ACCU_WIDTH-1:0]  accu_q;
        logic [31:0]            idx_q;
        logic [TIMER_WIDTH-1:0] max_q, min_q;
        logic                   overflow_q, orphan_q;

        assign empty  = (wr_ptr == rd_ptr);
        assign full   = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                        (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
        // Events count only while running and not frozen; clear wins over everything.
        assign accept = (state_q == ST_RUN) && go && !clear;
        assign pop    = accept && rx_event[c] && !empty;
        // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
        assign push   = accept && tx_event[c] && (!full || pop);
        assign pop_cnt_next = pop_cnt + 32'(pop);

        // DONE is entered on the pop count rather than idx so that samples still
        // in the delta pipeline never push idx past lat_pkt_cnt.
        always_comb begin
            state_d = state_q;
            if (clear) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (go) state_d = ST_RUN;
                    ST_RUN: begin
                        if ((lat_pkt_cnt != 32'd0) && (pop_cnt_next == lat_pkt_cnt)) begin
                            state_d = ST_DONE;
                        end else if (!go) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DONE: state_d = ST_DONE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge lat_clk or negedge lat_rstn) begin
            if (!lat_rstn) begin
                state_q    <= ST_IDLE;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                pop_cnt    <= '0;
                overflow_q <= 1'b0;
                orphan_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                if (clear) begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    pop_cnt    <= '0;
                    overflow_q <= 1'b0;
                    orphan_q   <= 1'b0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)  rd_ptr <= rd_ptr + 1'b1;
                    pop_cnt <= pop_cnt_next;
                    if (accept && tx_event[c] && full && !pop) overflow_q <= 1'b1;
                    if (accept && rx_event[c] && empty)        orphan_q   <= 1'b1;
                end
            end
        end

        always_ff @(posedge lat_clk) begin
            if (push) fifo_mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= timer_q;
        end

        // Stage 1: capture receive time and matching send time.
        always_ff @(posedge lat_clk or negedge lat_rstn) begin
            if (!lat_rstn) begin
                s1_valid <= 1'b0;
                s1_ts    <= '0;
                s1_head  <= '0;
            end else begin
                s1_valid <= pop;
                if (pop) begin
                    s1_ts   <= timer_q;
                    s1_head <= fifo_mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
                end
            end
        end

        assign raw      = s1_ts - s1_head;
        assign adj      = (raw >= delta_adj_factor) ? (raw - delta_adj_factor) : '0;
        assign accu_sum = (ACCU_WIDTH+1)'(accu_q) + (ACCU_WIDTH+1)'(adj);

        // Stage 2: statistics update.
        always_ff @(posedge lat_clk or negedge lat_rstn) begin
            if (!lat_rstn) begin
                accu_q <= '0;
                idx_q  <= '0;
                max_q  <= '0;
                min_q  <= '1;
            end else if (clear) begin
                accu_q <= '0;
                idx_q  <= '0;
                max_q  <= '0;
                min_q  <= '1;
            end else if (s1_valid) begin
                accu_q <= accu_sum[ACCU_WIDTH] ? '1 : accu_sum[ACCU_WIDTH-1:0];
                idx_q  <= idx_q + 32'd1;
                if (adj > max_q) max_q <= adj;
                if (adj < min_q) min_q <= adj;
            end
        end

        assign accu_a[c]      = accu_q;
        assign idx_a[c]       = idx_q;
        assign max_a[c]       = max_q;
        assign min_a[c]       = min_q;
        assign ch_done[c]     = (lat_pkt_cnt != 32'd0) && (idx_q == lat_pkt_cnt);
        assign ch_overflow[c] = overflow_q;
        assign ch_orphan[c]   = orphan_q;
    end

    assign all_done = (lat_pkt_cnt != 32'd0) && (&ch_done);

    assign sel_ext = 5'(rd_ch_sel);

    always_ff @(posedge lat_clk or negedge lat_rstn) begin
        if (!lat_rstn) begin
            rd_accu <= '0;
            rd_idx  <= '0;
            rd_max  <= '0;
            rd_min  <= '1;
        end else if (sel_ext < 5'(NUM_CH)) begin
            rd_accu <= accu_a[rd_ch_sel];
            rd_idx  <= idx_a[rd_ch_sel];
            rd_max  <= max_a[rd_ch_sel];
            rd_min  <= min_a[rd_ch_sel];
        end else begin
            rd_accu <= '0;
            rd_idx  <= '0;
            rd_max  <= '0;
            rd_min  <= '0;
        end
    end

endmodule

// File: tb/tb_gtfraw_vnc_lat_mon_mc.sv
// ---------------------------------------------------------------------------
// tb_gtfraw_vnc_lat_mon_mc
// Directed stimulus with hand-computed expectations queued on a scoreboard,
// each tagged with the cycle at which the DUT output must hold it; a
// separate monitor compares on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gtfraw_vnc_lat_mon_mc;

    logic        lat_clk = 1'b0;
    logic        lat_rstn = 1'b0;
    logic        go = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] lat_pkt_cnt = '0;
    logic [15:0] delta_adj_factor = '0;
    logic [3:0]  tx_event = '0;
    logic [3:0]  rx_event = '0;
    logic [1:0]  rd_ch_sel = '0;
    logic [15:0] timer;
    logic [31:0] rd_accu;
    logic [31:0] rd_idx;
    logic [15:0] rd_max;
    logic [15:0] rd_min;
    logic [3:0]  ch_done;
    logic [3:0]  ch_overflow;
    logic [3:0]  ch_orphan;
    logic        all_done;

    gtfraw_vnc_lat_mon_mc #(
        .NUM_CH(4),
        .TIMER_WIDTH(16),
        .FIFO_ADDR_WIDTH(4),
        .ACCU_WIDTH(32)
    ) dut (
        .lat_clk(lat_clk),
        .lat_rstn(lat_rstn),
        .go(go),
        .clear(clear),
        .lat_pkt_cnt(lat_pkt_cnt),
        .delta_adj_factor(delta_adj_factor),
        .tx_event(tx_event),
        .rx_event(rx_event),
        .rd_ch_sel(rd_ch_sel),
        .timer(timer),
        .rd_accu(rd_accu),
        .rd_idx(rd_idx),
        .rd_max(rd_max),
        .rd_min(rd_min),
        .ch_done(ch_done),
        .ch_overflow(ch_overflow),
        .ch_orphan(ch_orphan),
        .all_done(all_done)
    );

    always #5 lat_clk = ~lat_clk;

    int cyc = 0;
    always @(posedge lat_clk) cyc <= cyc + 1;

    // Reference timestamp used only to schedule events at given timer values.
    logic [15:0] ref_timer;
    always @(posedge lat_clk or negedge lat_rstn) begin
        if (!lat_rstn) ref_timer <= '0;
        else           ref_timer <= ref_timer + 16'd1;
    end

    typedef struct {
        string       name;
        int          due;
        int          kind;   // 0 = rd stats, 1 = status flags, 2 = timer
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] T5_ACCU [4] = '{32'd16, 32'd17, 32'd17, 32'd20};
    localparam logic [31:0] T5_MAX  [4] = '{32'd6,  32'd6,  32'd6,  32'd7};
    localparam logic [31:0] T5_MIN  [4] = '{32'd4,  32'd5,  32'd5,  32'd6};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input exp_t e);
        int pos;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > e.due) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic expect_rd(input string nm, input int due, input logic [31:0] accu,
                             input logic [31:0] idx, input logic [31:0] mx, input logic [31:0] mn);
        exp_t e;
        e.name = nm; e.due = due; e.kind = 0;
        e.a = accu; e.b = idx; e.c = mx; e.d = mn;
        push_exp(e);
    endtask

    task automatic expect_flags(input string nm, input int due, input logic [31:0] done,
                                input logic [31:0] ovf, input logic [31:0] orph, input logic [31:0] all);
        exp_t e;
        e.name = nm; e.due = due; e.kind = 1;
        e.a = done; e.b = ovf; e.c = orph; e.d = all;
        push_exp(e);
    endtask

    task automatic expect_timer(input string nm, input int due, input logic [31:0] t);
        exp_t e;
        e.name = nm; e.due = due; e.kind = 2;
        e.a = t; e.b = '0; e.c = '0; e.d = '0;
        push_exp(e);
    endtask

    always @(negedge lat_clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            case (cur.kind)
                0: begin
                    chk({cur.name, ".accu"}, rd_accu, cur.a);
                    chk({cur.name, ".idx"},  rd_idx,  cur.b);
                    chk({cur.name, ".max"},  32'(rd_max), cur.c);
                    chk({cur.name, ".min"},  32'(rd_min), cur.d);
                end
                1: begin
                    chk({cur.name, ".done"},     32'(ch_done),     cur.a);
                    chk({cur.name, ".overflow"}, 32'(ch_overflow), cur.b);
                    chk({cur.name, ".orphan"},   32'(ch_orphan),   cur.c);
                    chk({cur.name, ".all_done"}, 32'(all_done),    cur.d);
                end
                default: chk({cur.name, ".timer"}, 32'(timer), cur.a);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge lat_clk);
    endtask

    task automatic pulse(input logic [3:0] tx, input logic [3:0] rx);
        tx_event = tx;
        rx_event = rx;
        @(negedge lat_clk);
        tx_event = '0;
        rx_event = '0;
    endtask

    task automatic wait_timer(input logic [15:0] t);
        int n;
        n = 0;
        while (ref_timer !== t && n < 70000) begin
            @(negedge lat_clk);
            n++;
        end
        if (ref_timer !== t) begin
            checks++;
            errors++;
            $display("FAIL wait_timer: timer %0d never reached %0d", ref_timer, t);
        end
    endtask

    task automatic setup(input logic [31:0] cnt, input logic [15:0] adj);
        go = 1'b0;
        tick(1);
        lat_pkt_cnt = cnt;
        delta_adj_factor = adj;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        go = 1'b1;
        tick(2);
    endtask

    initial begin
        int n;

        // Reset state
        tick(1);
        expect_rd("rst_rd", cyc + 1, 32'd0, 32'd0, 32'd0, 32'hFFFF);
        expect_flags("rst_flags", cyc + 1, 32'd0, 32'd0, 32'd0, 32'd0);
        expect_timer("rst_timer", cyc + 1, 32'd0);
        tick(3);
        lat_rstn = 1'b1;

        // T2: tx at 100, rx at 150, adjust 10 -> 40
        setup(32'd0, 16'd10);
        wait_timer(16'd100);
        pulse(4'b0001, 4'b0000);
        wait_timer(16'd150);
        expect_rd("t2_latency", cyc + 2, 32'd0, 32'd0, 32'd0, 32'hFFFF);
        expect_flags("t2_flags", cyc + 2, 32'd0, 32'd0, 32'd0, 32'd0);
        expect_rd("t2", cyc + 3, 32'd40, 32'd1, 32'd40, 32'd40);
        pulse(4'b0000, 4'b0001);
        tick(4);

        // T3: wrap-around delta 10, adjust 20 -> floor at 0
        setup(32'd0, 16'd20);
        wait_timer(16'd65530);
        pulse(4'b0001, 4'b0000);
        wait_timer(16'd4);
        expect_timer("t3_wrap", cyc + 1, 32'd5);
        expect_rd("t3", cyc + 3, 32'd0, 32'd1, 32'd0, 32'd0);
        pulse(4'b0000, 4'b0001);
        tick(4);

        // T4: 17 sends into a 16-deep FIFO, then 17 receives
        setup(32'd0, 16'd0);
        wait_timer(16'd200);
        for (int i = 0; i < 17; i++) begin
            if (i == 15) expect_flags("t4_full_no_ovf", cyc + 1, 32'd0, 32'd0, 32'd0, 32'd0);
            if (i == 16) expect_flags("t4_ovf", cyc + 1, 32'd0, 32'd1, 32'd0, 32'd0);
            pulse(4'b0001, 4'b0000);
        end
        wait_timer(16'd300);
        for (int j = 0; j < 16; j++) begin
            if (j == 15) expect_rd("t4_16", cyc + 3, 32'd1600, 32'd16, 32'd100, 32'd100);
            pulse(4'b0000, 4'b0001);
        end
        expect_flags("t4_orphan", cyc + 1, 32'd0, 32'd1, 32'd1, 32'd0);
        expect_rd("t4_after_orphan", cyc + 3, 32'd1600, 32'd16, 32'd100, 32'd100);
        pulse(4'b0000, 4'b0001);
        tick(4);

        // T5: four interleaved channels, 3 samples each
        setup(32'd3, 16'd0);
        wait_timer(16'd400);
        pulse(4'b1011, 4'b0000);                               // 400
        expect_flags("t5_orphan2", cyc + 1, 32'd0, 32'd0, 32'h4, 32'd0);
        pulse(4'b0100, 4'b0100);                               // 401
        pulse(4'b1111, 4'b0000);                               // 402
        pulse(4'b1111, 4'b0000);                               // 403
        pulse(4'b0000, 4'b0001);                               // 404
        pulse(4'b0000, 4'b0010);                               // 405
        pulse(4'b0000, 4'b0100);                               // 406
        pulse(4'b0000, 4'b1000);                               // 407
        pulse(4'b0000, 4'b1111);                               // 408
        expect_flags("t5_pre_done", cyc + 1, 32'd0, 32'd0, 32'h4, 32'd0);
        expect_flags("t5_done012", cyc + 2, 32'h7, 32'd0, 32'h4, 32'd0);
        pulse(4'b0000, 4'b0111);                               // 409
        expect_flags("t5_all", cyc + 2, 32'hF, 32'd0, 32'h4, 32'd1);
        pulse(4'b0000, 4'b1111);                               // 410
        pulse(4'b0000, 4'b1000);                               // 411
        tick(4);
        for (int c = 0; c < 4; c++) begin
            rd_ch_sel = 2'(c);
            expect_rd($sformatf("t5_ch%0d", c), cyc + 1, T5_ACCU[c], 32'd3, T5_MAX[c], T5_MIN[c]);
            tick(1);
        end
        rd_ch_sel = 2'd0;
        expect_flags("t5_final", cyc + 1, 32'hF, 32'd0, 32'h4, 32'd1);
        tick(2);

        // T6: clear in the same cycle as a receive event
        setup(32'd0, 16'd0);
        wait_timer(16'd500);
        pulse(4'b0001, 4'b0000);
        wait_timer(16'd503);
        expect_rd("t6_pre", cyc + 3, 32'd3, 32'd1, 32'd3, 32'd3);
        pulse(4'b0000, 4'b0001);                               // 503
        pulse(4'b0001, 4'b0000);                               // 504
        wait_timer(16'd510);
        expect_flags("t6_flags", cyc + 1, 32'd0, 32'd0, 32'd0, 32'd0);
        expect_rd("t6_cleared", cyc + 3, 32'd0, 32'd0, 32'd0, 32'hFFFF);
        clear = 1'b1;
        pulse(4'b0000, 4'b0001);                               // 510
        clear = 1'b0;
        wait_timer(16'd513);
        expect_flags("t6_fifo_cleared", cyc + 1, 32'd0, 32'd0, 32'd1, 32'd0);
        expect_rd("t6_idx0", cyc + 3, 32'd0, 32'd0, 32'd0, 32'hFFFF);
        pulse(4'b0000, 4'b0001);                               // 513

        // T1: asynchronous reset in the middle of a run
        wait_timer(16'd530);
        pulse(4'b0001, 4'b0000);
        wait_timer(16'd532);
        expect_rd("t1_pre", cyc + 3, 32'd2, 32'd1, 32'd2, 32'd2);
        pulse(4'b0000, 4'b0001);
        tick(4);
        #2;
        lat_rstn = 1'b0;
        expect_rd("t1_rd", cyc + 1, 32'd0, 32'd0, 32'd0, 32'hFFFF);
        expect_flags("t1_flags", cyc + 1, 32'd0, 32'd0, 32'd0, 32'd0);
        expect_timer("t1_timer", cyc + 1, 32'd0);
        tick(3);
        lat_rstn = 1'b1;
        expect_timer("t1_restart", cyc + 2, 32'd2);
        tick(3);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked (due cycle %0d, now %0d)", cur.name, cur.due, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
